// File: rtl/key_scan_driver.sv
// key_scan_driver: walks every WIDTH-bit pattern in ascending order into an
// external combinational checker, samples its match output after a settle
// window and accumulates hit count, first hit and last hit.
// Optional feature macro: STOP_ON_FIRST_HIT_EN ends the scan on the first hit.
module key_scan_driver #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2   // 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             match_in,
  output logic [WIDTH-1:0] pat_out,
  output logic             pat_valid,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH:0]   hit_count,
  output logic [WIDTH-1:0] first_hit,
  output logic [WIDTH-1:0] last_hit,
  output logic             hit_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [WIDTH-1:0] PAT_MAX  = '1;
  localparam logic [WIDTH-1:0] PAT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   HIT_ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [3:0]       CNT_LAST = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       hit_stop;

`ifdef STOP_ON_FIRST_HIT_EN
  assign hit_stop = match_in;
`else
  assign hit_stop = 1'b0;
`endif

  assign busy      = (state == DRIVE) || (state == SAMPLE);
  assign pat_valid = busy;
  assign done      = (state == DONE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state: abort beats everything except reset; the last pattern,
  // or a stopping hit, ends the scan from SAMPLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = DRIVE;
      DRIVE:  if (abort) state_nx = DONE;
              else if (cnt == CNT_LAST) state_nx = SAMPLE;
      SAMPLE: if (abort || hit_stop || (pat_out == PAT_MAX)) state_nx = DONE;
              else state_nx = DRIVE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // datapath: pattern/settle counters and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_out   <= '0;
      cnt       <= '0;
      hit_count <= '0;
      first_hit <= '0;
      last_hit  <= '0;
      hit_valid <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pat_out   <= '0;
            cnt       <= '0;
            hit_count <= '0;
            first_hit <= '0;
            last_hit  <= '0;
            hit_valid <= 1'b0;
            aborted   <= 1'b0;
          end
        end
        DRIVE: begin
          cnt <= cnt + 4'd1;
          if (abort) aborted <= 1'b1;
        end
        SAMPLE: begin
          // a sample coinciding with abort still counts
          if (match_in) begin
            hit_count <= hit_count + HIT_ONE;
            last_hit  <= pat_out;
            if (!hit_valid) first_hit <= pat_out;
            hit_valid <= 1'b1;
          end
          if (abort) aborted <= 1'b1;
          // pattern only advances when the scan continues, so it never wraps
          if (state_nx == DRIVE) begin
            pat_out <= pat_out + PAT_ONE;
            cnt     <= '0;
          end
        end
        default: ;  // DONE: hold everything
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan_driver.sv
// Directed self-checking bench for key_scan_driver (WIDTH=8, SETTLE=2).
// The checker is modelled combinationally from pat_out, selected by mode.
module tb_key_scan_driver;

  logic       clk = 1'b0;
  logic       rst, start, abort, match_in;
  logic [7:0] pat_out, first_hit, last_hit;
  logic [8:0] hit_count;
  logic       pat_valid, busy, done, aborted, hit_valid;

  int errors = 0;
  int checks = 0;
  int mode   = 0;
  int cycles;
  bit seen_done;

  key_scan_driver #(.WIDTH(8), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .match_in(match_in),
    .pat_out(pat_out), .pat_valid(pat_valid), .busy(busy), .done(done),
    .aborted(aborted), .hit_count(hit_count), .first_hit(first_hit),
    .last_hit(last_hit), .hit_valid(hit_valid)
  );

  always #5 clk = ~clk;

  // external checker model
  always_comb begin
    match_in = 1'b0;
    case (mode)
      1: match_in = (pat_out == 8'hA5);
      2: match_in = pat_out[7];
      3: match_in = 1'b1;
      4: match_in = (pat_out == 8'h03);
      5: match_in = (pat_out >= 8'h40);
      default: match_in = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pulse start, then count cycles from the first DRIVE cycle to done;
  // a stray start pulse mid-scan must not disturb anything
  task automatic run_scan(input int m, output int n);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 5000) begin
      start = (n == 100);
      tick();
      n++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy",      busy,      0);
    check("reset_pat_out",   pat_out,   0);
    check("reset_hit_count", hit_count, 0);
    check("reset_done",      done,      0);
    check("reset_hit_valid", hit_valid, 0);

    // reset mid-scan with hits already recorded
    mode = 3; start = 1'b1; tick(); start = 1'b0;
    check("scan_pat_valid", pat_valid, 1);
    check("scan_pat0",      pat_out,   0);
    repeat (40) tick();
    check("midscan_hits_nonzero", (hit_count != 0), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_busy",      busy,      0);
    check("midrst_pat_out",   pat_out,   0);
    check("midrst_hit_count", hit_count, 0);
    check("midrst_hit_valid", hit_valid, 0);
    seen_done = 1'b0;
    repeat (20) begin tick(); if (done) seen_done = 1'b1; end
    check("midrst_no_done", seen_done, 0);

    // single hit at A5; full scan is 256*3 cycles
    run_scan(1, cycles);
    check("single_cycles",  cycles,    768);
    check("single_count",   hit_count, 1);
    check("single_first",   first_hit, 8'hA5);
    check("single_last",    last_hit,  8'hA5);
    check("single_valid",   hit_valid, 1);
    check("single_aborted", aborted,   0);
    check("single_pat_hold", pat_out,  8'hFF);
    check("single_pat_valid", pat_valid, 0);
    // start during DONE is ignored
    start = 1'b1; tick(); start = 1'b0;
    check("done_pulse_len",   done, 0);
    check("start_in_done_ign", busy, 0);
    tick();

`ifdef STOP_ON_FIRST_HIT_EN
    // stop at the first hit, 8'h40: 64 patterns * 3 + 3 cycles
    run_scan(5, cycles);
    check("stop_cycles",  cycles,    195);
    check("stop_count",   hit_count, 1);
    check("stop_first",   first_hit, 8'h40);
    check("stop_last",    last_hit,  8'h40);
    check("stop_pat",     pat_out,   8'h40);
    check("stop_aborted", aborted,   0);
    tick(); tick();
`else
    // upper half matches
    run_scan(2, cycles);
    check("many_cycles", cycles,    768);
    check("many_count",  hit_count, 128);
    check("many_first",  first_hit, 8'h80);
    check("many_last",   last_hit,  8'hFF);
    tick(); tick();

    // no hits
    run_scan(0, cycles);
    check("none_count", hit_count, 0);
    check("none_valid", hit_valid, 0);
    tick(); tick();

    // every pattern hits: count must reach 256 without wrapping
    run_scan(3, cycles);
    check("all_count", hit_count, 9'h100);
    check("all_first", first_hit, 8'h00);
    check("all_last",  last_hit,  8'hFF);
    check("all_valid", hit_valid, 1);
    tick(); tick();
`endif

    // abort while driving 8'h10
    mode = 4; start = 1'b1; tick(); start = 1'b0;
    cycles = 0;
    while (pat_out != 8'h10 && cycles < 200) begin tick(); cycles++; end
    check("abort_reach_10", pat_out, 8'h10);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_done",    done,      1);
    check("abort_flag",    aborted,   1);
    check("abort_count",   hit_count, 1);
    check("abort_first",   first_hit, 8'h03);
    check("abort_pat",     pat_out,   8'h10);
    tick();
    check("abort_done_clr", done,    0);
    check("abort_held",     aborted, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle_ign", busy, 0);
    // a new start clears the sticky results
    mode = 0; start = 1'b1; tick(); start = 1'b0;
    check("restart_aborted", aborted,   0);
    check("restart_count",   hit_count, 0);
    check("restart_busy",    busy,      1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
